// File: rtl/lsu_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ram_ctrl
// Description : Load/store unit front end for a synchronous-read 32-bit data
//               RAM. Handles RV32I byte/half/word loads with sign or zero
//               extension, word stores in one cycle, sub-word stores via
//               read-modify-write, and misaligned/illegal request rejection.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ram_ctrl #(
   parameter int ADDRWIDTH = 6
) (
   input  logic                 iClk,
   input  logic                 iRst,
   input  logic                 iReq,
   input  logic                 iWE,
   input  logic [2:0]           iFunct3,
   input  logic [ADDRWIDTH+1:0] iAddr,
   input  logic [31:0]          iWData,
   output logic                 oReady,
   output logic                 oDone,
   output logic [31:0]          oRData,
   output logic                 oMisalign,
   output logic                 oRamWR,
   output logic [ADDRWIDTH-1:0] oRamAddr,
   output logic [31:0]          oRamWData,
   input  logic [31:0]          iRamRData
);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      RMW_WRITE = 2'd2,
      ERR       = 2'd3
   } state_t;

   state_t                 state;
   logic [ADDRWIDTH-1:0]   lat_waddr;
   logic [1:0]             lat_off;
   logic [2:0]             lat_funct3;
   logic [15:0]            lat_data;

   logic                   accept;
   logic                   req_err;
   logic                   sw_now;
   logic [7:0]             sel_byte;
   logic [15:0]            sel_half;
   logic [31:0]            load_ext;
   logic [31:0]            merged;

   // Request legality: funct3 must be meaningful for the direction, and the
   // byte address must be naturally aligned for the access size.
   always_comb begin
      req_err = 1'b0;
      if (iWE) begin
         if (!(iFunct3 == F3_B || iFunct3 == F3_H || iFunct3 == F3_W))
            req_err = 1'b1;
      end else begin
         if (!(iFunct3 == F3_B || iFunct3 == F3_H || iFunct3 == F3_W ||
               iFunct3 == F3_BU || iFunct3 == F3_HU))
            req_err = 1'b1;
      end
      if ((iFunct3 == F3_H || iFunct3 == F3_HU) && iAddr[0])
         req_err = 1'b1;
      if (iFunct3 == F3_W && (iAddr[1:0] != 2'b00))
         req_err = 1'b1;
   end

   assign oReady = (state == IDLE) && !iRst;
   assign accept = iReq && oReady;
   assign sw_now = accept && !req_err && iWE && (iFunct3 == F3_W);

   // Lane selection and extension of the RAM word for a pending load.
   always_comb begin
      sel_byte = iRamRData[{lat_off, 3'b000} +: 8];
      sel_half = iRamRData[{lat_off[1], 4'b0000} +: 16];
      case (lat_funct3)
         F3_B:    load_ext = {{24{sel_byte[7]}}, sel_byte};
         F3_BU:   load_ext = {24'h000000, sel_byte};
         F3_H:    load_ext = {{16{sel_half[15]}}, sel_half};
         F3_HU:   load_ext = {16'h0000, sel_half};
         default: load_ext = iRamRData;
      endcase
   end

   // Sub-word store merge: replace the addressed lane of the old RAM word.
   always_comb begin
      merged = iRamRData;
      if (lat_funct3 == F3_H)
         merged[{lat_off[1], 4'b0000} +: 16] = lat_data;
      else
         merged[{lat_off, 3'b000} +: 8] = lat_data[7:0];
   end

   // RAM port: address follows the core while idle so the RAM samples it on
   // the accept edge; writes are suppressed while reset is asserted.
   always_comb begin
      oRamAddr  = (state == IDLE) ? iAddr[ADDRWIDTH+1:2] : lat_waddr;
      oRamWR    = sw_now || ((state == RMW_WRITE) && !iRst);
      oRamWData = (state == RMW_WRITE) ? merged : iWData;
   end

   // Controller state machine with registered completion outputs.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state      <= IDLE;
         oDone      <= 1'b0;
         oMisalign  <= 1'b0;
         oRData     <= 32'h0000_0000;
         lat_waddr  <= '0;
         lat_off    <= 2'b00;
         lat_funct3 <= 3'b000;
         lat_data   <= 16'h0000;
      end else begin
         oDone     <= 1'b0;
         oMisalign <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_waddr  <= iAddr[ADDRWIDTH+1:2];
                  lat_off    <= iAddr[1:0];
                  lat_funct3 <= iFunct3;
                  lat_data   <= iWData[15:0];
                  if (req_err) begin
                     state     <= ERR;
                     oDone     <= 1'b1;
                     oMisalign <= 1'b1;
                  end else if (!iWE) begin
                     state <= LOAD_WAIT;
                  end else if (iFunct3 == F3_W) begin
                     oDone <= 1'b1;
                  end else begin
                     state <= RMW_WRITE;
                  end
               end
            end
            LOAD_WAIT: begin
               oRData <= load_ext;
               oDone  <= 1'b1;
               state  <= IDLE;
            end
            RMW_WRITE: begin
               oDone <= 1'b1;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/lsu_ram_ctrl.md
LSU_RAM_CTRL -- requirements
Module: lsu_ram_ctrl

Interface
REQ-001 Parameter ADDRWIDTH, default 6: word-address width of the attached data RAM (RAM depth = 2^ADDRWIDTH words).
REQ-002 Data width SHALL be fixed at 32; byte address width is ADDRWIDTH+2.
REQ-003 iClk  in  1  the single clock; all state changes on its rising edge.
REQ-004 iRst  in  1  reset; synchronous and active-high.
REQ-005 iReq  in  1  core access request.
REQ-006 iWE  in  1  1 = store, 0 = load.
REQ-007 iFunct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-008 iAddr  in  ADDRWIDTH+2  byte address.
REQ-009 iWData  in  32  store data; byte/half taken from low bits.
REQ-010 oReady  out  1  controller can accept a request this cycle.
REQ-011 oDone  out  1  one-cycle completion pulse, one per accepted request.
REQ-012 oRData  out  32  extended load result, valid while oDone=1.
REQ-013 oMisalign  out  1  accepted request rejected (misaligned or illegal funct3), valid while oDone=1.
REQ-014 oRamWR, oRamAddr[ADDRWIDTH-1:0], oRamWData[31:0]  out  RAM write enable, word address, write data.
REQ-015 iRamRData  in  32  RAM read data, valid one cycle after the address is sampled (synchronous read).

Function
REQ-016 States SHALL be IDLE, LOAD_WAIT, RMW_WRITE, ERR; oReady=1 only in IDLE with iRst=0.
REQ-017 Accept = iReq & oReady at a rising edge; in IDLE oRamAddr = iAddr[ADDRWIDTH+1:2] combinationally so the RAM samples it on the accept edge.
REQ-018 Error on accept: H/HU with iAddr[0]=1; W with iAddr[1:0]!=0; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
REQ-019 Error request: no RAM write; IDLE->ERR; in ERR, oDone=1 and oMisalign=1 for one cycle, then IDLE; oRData unchanged.
REQ-020 Load: IDLE->LOAD_WAIT; in LOAD_WAIT select byte by addr[1:0] or half by addr[1], sign-extend (B,H) or zero-extend (BU,HU), register into oRData with oDone=1 on the next edge; ->IDLE; accept-to-oDone latency 2 edges.
REQ-021 SW: oRamWR=1, oRamWData=iWData combinationally in the accept cycle; oDone=1 after that edge; state stays IDLE; latency 1.
REQ-022 SB/SH: read-modify-write; accept edge latches word address, offset, funct3, data; IDLE->RMW_WRITE.
REQ-023 In RMW_WRITE: oRamWR=1, oRamAddr=latched word address, oRamWData=iRamRData with the addressed byte/half replaced; oDone=1 after that edge; ->IDLE; latency 2.
REQ-024 oRamWR SHALL be 0 in all cases not covered by REQ-021/REQ-023.
REQ-025 oDone/oMisalign SHALL be registered and high exactly one cycle per request; oMisalign=0 whenever oDone=0; oRData holds its last load value across store and error completions.
REQ-026 A new request MAY be accepted in the same cycle oDone is high (back-to-back); iReq while oReady=0 is ignored and must be held by the core.
REQ-027 A load following a store to the same word SHALL return the stored value.

Reset
REQ-028 While iRst=1: state<=IDLE, oDone<=0, oMisalign<=0, oRData<=0, oReady=0, oRamWR=0.
REQ-029 Reset mid-operation (LOAD_WAIT or RMW_WRITE) SHALL abort the request: no write, no oDone.

Verification
REQ-030 SW 0x12345678 @0x04, then LW @0x04 -> oDone 2 edges after accept, oRData=0x12345678, oMisalign=0.
REQ-031 SB 0xAB @0x05 over word 0x12345678, then LB @0x05 -> 0xFFFFFFAB; LBU @0x05 -> 0x000000AB; LW @0x04 -> 0x1234AB78.
REQ-032 SH 0x8001 @0x06, then LH @0x06 -> 0xFFFF8001; LHU -> 0x00008001; word -> 0x8001xxxx with low half untouched.
REQ-033 LW @0x02, SH @0x03, load funct3=011 -> each gives oDone=1, oMisalign=1, no oRamWR pulse, RAM unchanged.
REQ-034 iRst=1 asserted in RMW_WRITE of SB @0x08 -> no write, no oDone, RAM word unchanged, oReady=1 the cycle after iRst falls.
REQ-035 Back-to-back SW, SW, LW with iReq held high -> accepts on consecutive ready cycles, exactly three oDone pulses, last oRData = second SW data when same address.
